dmem_responder: RTL and testbench

- Slave end of the core's data-memory port. Serves the core's address, write-data, write-enable, read-enable and size signals.
- Returns read data in the same cycle, because the MEM stage has no stall.
- Contains a word-organised data RAM, byte/halfword lane steering with load extension, and a small MMIO window: a 64-bit cycle timer with compare interrupt, and a tohost/exit register for simulation finish.
- Sits beside the core top and replaces the bare external RAM.

---
 rtl/dmem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave for the core: word RAM with lane steering, plus an MMIO timer and tohost window.
// Define DMEM_PERF_EN to add load/store access counters at MMIO offsets 0x18/0x1C.
module dmem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o,
  output logic        timer_irq_o,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic        err_o
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [3:0] OFF_MTIME_LO = 4'd0;
  localparam logic [3:0] OFF_MTIME_HI = 4'd1;
  localparam logic [3:0] OFF_CMP_LO   = 4'd2;
  localparam logic [3:0] OFF_CMP_HI   = 4'd3;
  localparam logic [3:0] OFF_TOHOST   = 4'd4;
`ifdef DMEM_PERF_EN
  localparam logic [3:0] OFF_LOAD_CNT  = 4'd6;
  localparam logic [3:0] OFF_STORE_CNT = 4'd7;
`endif

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_word;

  logic        size_ok;
  logic        is_word;
  logic        misaligned;
  logic        ram_hit;
  logic        mmio_hit;
  logic        access_ok;
  logic        ram_ok;
  logic        mmio_ok;
  logic        bad_access;
  logic [3:0]  mmio_off;
  logic        mmio_we;
  logic        mmio_re;
  logic        ram_we;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ram_load;
  logic [31:0] mmio_rdata;
  logic [3:0]  byte_en;
  logic [31:0] wdata;

  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [31:0] hi_latch;

`ifdef DMEM_PERF_EN
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
`endif

  assign ram_idx  = addr_i[IDX_W+1:2];
  assign ram_word = mem[ram_idx];
  assign mmio_off = addr_i[5:2];

  // Size legality and natural alignment; stores reuse the B/H codes of the unsigned loads.
  always_comb begin
    size_ok    = 1'b1;
    is_word    = 1'b0;
    misaligned = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: misaligned = 1'b0;
      SZ_H, SZ_HU: misaligned = addr_i[0];
      SZ_W: begin
        is_word    = 1'b1;
        misaligned = |addr_i[1:0];
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign ram_hit    = ({1'b0, addr_i} < RAM_BYTES);
  assign mmio_hit   = (addr_i[31:6] == MMIO_BASE[31:6]);
  assign access_ok  = size_ok && !misaligned && (ram_hit || (mmio_hit && is_word));
  assign ram_ok     = access_ok && ram_hit;
  assign mmio_ok    = access_ok && !ram_hit && mmio_hit;
  assign bad_access = (we_i || re_i) && !access_ok;
  assign mmio_we    = we_i && mmio_ok;
  assign mmio_re    = re_i && mmio_ok;
  assign ram_we     = we_i && ram_ok;

  always_comb begin
    byte_sel = ram_word[7:0];
    case (addr_i[1:0])
      2'd0: byte_sel = ram_word[7:0];
      2'd1: byte_sel = ram_word[15:8];
      2'd2: byte_sel = ram_word[23:16];
      2'd3: byte_sel = ram_word[31:24];
      default: byte_sel = ram_word[7:0];
    endcase
    half_sel = addr_i[1] ? ram_word[31:16] : ram_word[15:0];
  end

  always_comb begin
    ram_load = 32'd0;
    case (size_i)
      SZ_B:  ram_load = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU: ram_load = {24'd0, byte_sel};
      SZ_H:  ram_load = {{16{half_sel[15]}}, half_sel};
      SZ_HU: ram_load = {16'd0, half_sel};
      SZ_W:  ram_load = ram_word;
      default: ram_load = 32'd0;
    endcase
  end

  always_comb begin
    mmio_rdata = 32'd0;
    case (mmio_off)
      OFF_MTIME_LO:  mmio_rdata = mtime[31:0];
      OFF_MTIME_HI:  mmio_rdata = hi_latch;
      OFF_CMP_LO:    mmio_rdata = mtimecmp[31:0];
      OFF_CMP_HI:    mmio_rdata = mtimecmp[63:32];
`ifdef DMEM_PERF_EN
      OFF_LOAD_CNT:  mmio_rdata = load_cnt;
      OFF_STORE_CNT: mmio_rdata = store_cnt;
`endif
      default:       mmio_rdata = 32'd0;
    endcase
  end

  // Any rejected access reads as zero, so the core never sees stale RAM data on a fault.
  always_comb begin
    data_o = 32'd0;
    if (re_i) begin
      if (ram_ok)
        data_o = ram_load;
      else if (mmio_ok)
        data_o = mmio_rdata;
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    wdata   = data_i;
    case (size_i)
      SZ_B, SZ_BU: begin
        byte_en = 4'b0001 << addr_i[1:0];
        wdata   = {4{data_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        byte_en = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data_i[15:0]}};
      end
      SZ_W: begin
        byte_en = 4'b1111;
        wdata   = data_i;
      end
      default: begin
        byte_en = 4'b0000;
        wdata   = data_i;
      end
    endcase
  end

  // RAM has no reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign mtime_next = mtime + 64'd1;

  // The compare uses the register value before any same-edge mtimecmp write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime       <= 64'd0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_latch    <= 32'd0;
      timer_irq_o <= 1'b0;
    end else begin
      mtime       <= mtime_next;
      timer_irq_o <= (mtime_next >= mtimecmp);
      if (mmio_re && (mmio_off == OFF_MTIME_LO))
        hi_latch <= mtime[63:32];
      if (mmio_we && (mmio_off == OFF_CMP_LO))
        mtimecmp[31:0] <= data_i;
      if (mmio_we && (mmio_off == OFF_CMP_HI))
        mtimecmp[63:32] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o      <= 1'b0;
      exit_code_o <= 32'd0;
      err_o       <= 1'b0;
    end else begin
      if (mmio_we && (mmio_off == OFF_TOHOST)) begin
        done_o      <= 1'b1;
        exit_code_o <= data_i;
      end
      if (bad_access)
        err_o <= 1'b1;
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
    end else begin
      if (re_i && access_ok)
        load_cnt <= load_cnt + 32'd1;
      if (we_i && access_ok)
        store_cnt <= store_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, alignment errors, timer compare, tohost and async reset.
module tb_dmem_responder;

  localparam logic [31:0] MMIO = 32'h1000_0000;
  localparam logic [2:0]  SZ_B  = 3'b000;
  localparam logic [2:0]  SZ_H  = 3'b001;
  localparam logic [2:0]  SZ_W  = 3'b010;
  localparam logic [2:0]  SZ_BU = 3'b100;
  localparam logic [2:0]  SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic        re_i;
  logic [2:0]  size_i;
  logic [31:0] data_o;
  logic        timer_irq_o;
  logic        done_o;
  logic [31:0] exit_code_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_mtime;

  dmem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .we_i        (we_i),
    .re_i        (re_i),
    .size_i      (size_i),
    .data_o      (data_o),
    .timer_irq_o (timer_irq_o),
    .done_o      (done_o),
    .exit_code_o (exit_code_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: mtime should equal the number of edges since reset released.
  always @(posedge clk or posedge rst) begin
    if (rst) model_mtime <= 64'd0;
    else     model_mtime <= model_mtime + 64'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    we_i   = we;
    re_i   = re;
    size_i = sz;
    addr_i = a;
    data_i = d;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, sz, a, d);
    stepEdge();
    applyStimulus(1'b0, 1'b0, SZ_W, 32'd0, 32'd0);
  endtask

  task automatic doLoad(input string tag, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] expected);
    applyStimulus(1'b0, 1'b1, sz, a, 32'd0);
    #1;
    checkOutput(tag, data_o, expected);
    stepEdge();
    applyStimulus(1'b0, 1'b0, SZ_W, 32'd0, 32'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    stepEdge();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, SZ_W, MMIO, 32'd0);
    #2;
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_exit", exit_code_o, 32'd0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_irq", timer_irq_o, 1'b0);
    checkOutput("rst_mtime_lo", data_o, 32'd0);
    re_i = 1'b0;
    #1;
    checkOutput("rst_no_re", data_o, 32'd0);
    #18 rst = 1'b0;
    stepEdge();

    // Timer compare at 40, then move it far away again.
    doStore(SZ_W, MMIO + 32'h0C, 32'd0);
    doStore(SZ_W, MMIO + 32'h08, 32'd40);
    for (int i = 0; i < 80; i++) begin
      checkOutput("irq_cmp40", timer_irq_o, (model_mtime >= 64'd40));
      if (model_mtime >= 64'd45) break;
      stepEdge();
    end
    if (model_mtime < 64'd45)
      checkOutput("irq_loop_bound", model_mtime, 64'd45);
    doStore(SZ_W, MMIO + 32'h08, 32'hFFFF_FFFF);
    checkOutput("irq_old_cmp", timer_irq_o, 1'b1);
    stepEdge();
    checkOutput("irq_dropped", timer_irq_o, 1'b0);
    doLoad("cmp_lo_rd", SZ_W, MMIO + 32'h08, 32'hFFFF_FFFF);
    doLoad("cmp_hi_rd", SZ_W, MMIO + 32'h0C, 32'd0);

    doStore(SZ_W, MMIO, 32'hDEAD_BEEF);
    doLoad("mtime_lo_ro", SZ_W, MMIO, model_mtime[31:0]);
    doLoad("unused_off", SZ_W, MMIO + 32'h14, 32'd0);
    checkOutput("mmio_no_err", err_o, 1'b0);

    // RAM lane steering and extension.
    doStore(SZ_W, 32'h100, 32'h1122_3344);
    doLoad("lb_101", SZ_B, 32'h101, 32'h0000_0033);
    doLoad("lbu_103", SZ_BU, 32'h103, 32'h0000_0011);
    doLoad("lh_102", SZ_H, 32'h102, 32'h0000_1122);
    doLoad("lw_100", SZ_W, 32'h100, 32'h1122_3344);
    doStore(SZ_W, 32'h104, 32'd0);
    doStore(SZ_B, 32'h104, 32'h0000_0080);
    doLoad("lb_104", SZ_B, 32'h104, 32'hFFFF_FF80);
    doLoad("lbu_104", SZ_BU, 32'h104, 32'h0000_0080);
    doLoad("lw_104", SZ_W, 32'h104, 32'h0000_0080);
    doStore(SZ_H, 32'h106, 32'h0000_BEEF);
    doLoad("lhu_106", SZ_HU, 32'h106, 32'h0000_BEEF);
    doLoad("lh_106", SZ_H, 32'h106, 32'hFFFF_BEEF);
    doLoad("lw_104_sh", SZ_W, 32'h104, 32'hBEEF_0080);

    applyStimulus(1'b1, 1'b1, SZ_W, 32'h100, 32'hCAFE_F00D);
    #1;
    checkOutput("rw_pre_data", data_o, 32'h1122_3344);
    stepEdge();
    applyStimulus(1'b0, 1'b0, SZ_W, 32'd0, 32'd0);
    doLoad("rw_post_data", SZ_W, 32'h100, 32'hCAFE_F00D);
    doStore(SZ_W, 32'h100, 32'h1122_3344);
    checkOutput("ram_no_err", err_o, 1'b0);

    // Error cases, each from a clean err_o.
    doLoad("lw_misaligned", SZ_W, 32'h102, 32'd0);
    checkOutput("err_lw_mis", err_o, 1'b1);
    pulseReset();
    checkOutput("err_cleared", err_o, 1'b0);
    doStore(SZ_H, 32'h105, 32'h0000_BEEF);
    checkOutput("err_sh_mis", err_o, 1'b1);
    doLoad("sh_mis_nowrite", SZ_W, 32'h104, 32'hBEEF_0080);
    pulseReset();
    doLoad("mmio_byte", SZ_B, MMIO + 32'h08, 32'd0);
    checkOutput("err_mmio_byte", err_o, 1'b1);
    pulseReset();
    doLoad("unmapped", SZ_W, 32'h2000_0000, 32'd0);
    checkOutput("err_unmapped", err_o, 1'b1);
    pulseReset();
    doLoad("bad_size", 3'b011, 32'h100, 32'd0);
    checkOutput("err_bad_size", err_o, 1'b1);
    pulseReset();

    // tohost and tear-free mtime read.
    applyStimulus(1'b1, 1'b0, SZ_W, MMIO + 32'h10, 32'd1);
    #1;
    checkOutput("done_before", done_o, 1'b0);
    stepEdge();
    applyStimulus(1'b0, 1'b0, SZ_W, 32'd0, 32'd0);
    checkOutput("done_set", done_o, 1'b1);
    checkOutput("exit_1", exit_code_o, 32'd1);
    doLoad("tohost_rd", SZ_W, MMIO + 32'h10, 32'd0);
    doStore(SZ_W, MMIO + 32'h10, 32'h0000_002A);
    checkOutput("exit_2a", exit_code_o, 32'h0000_002A);
    checkOutput("done_held", done_o, 1'b1);
    doLoad("mtime_lo", SZ_W, MMIO, model_mtime[31:0]);
    doLoad("mtime_hi", SZ_W, MMIO + 32'h04, 32'd0);

    // Async reset mid-cycle with done and err both set.
    doLoad("lw_mis_2", SZ_W, 32'h102, 32'd0);
    repeat (50) stepEdge();
    checkOutput("pre_rst_done", done_o, 1'b1);
    checkOutput("pre_rst_err", err_o, 1'b1);
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, SZ_W, MMIO, 32'd0);
    #1;
    checkOutput("async_done", done_o, 1'b0);
    checkOutput("async_exit", exit_code_o, 32'd0);
    checkOutput("async_err", err_o, 1'b0);
    checkOutput("async_irq", timer_irq_o, 1'b0);
    checkOutput("async_mtime", data_o, 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, SZ_W, 32'd0, 32'd0);
    stepEdge();
    doLoad("mtime_after_rst", SZ_W, MMIO, model_mtime[31:0]);
    doLoad("ram_kept", SZ_W, 32'h100, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
